// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: shared types and the requester-side request/response bundle.
package data_mem_pkg;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } write_width_t;
endpackage

interface data_mem_arbiter_if;
   import data_mem_pkg::*;
   logic             valid;
   logic             ready;
   logic [XLEN-1:0]  addr;
   logic [XLEN-1:0]  w_data;
   write_width_t     w_width;
   logic             w_enable;
   logic             rsp_valid;
   logic [XLEN-1:0]  rsp_r_data;
   modport master (output valid, addr, w_data, w_width, w_enable,
                   input  ready, rsp_valid, rsp_r_data);
   modport slave  (input  valid, addr, w_data, w_width, w_enable,
                   output ready, rsp_valid, rsp_r_data);
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin core/debug arbiter onto the single data memory port,
// with a tag pipeline routing each response back to its owner.
module data_mem_arbiter
   import data_mem_pkg::*;
#(
   parameter int READ_LATENCY = 0
) (
   input  logic               clock,
   input  logic               reset_n,
   data_mem_arbiter_if.slave  core,
   data_mem_arbiter_if.slave  dbg,
   output logic [XLEN-1:0]    mem_addr,
   output logic [XLEN-1:0]    mem_w_data,
   output write_width_t       mem_w_width,
   output logic               mem_w_enable,
   input  logic [XLEN-1:0]    mem_r_data
);
   typedef struct packed {
      logic vld;
      logic own;
      logic wr;
   } tag_t;

   logic last_grant;
   logic core_win;
   logic dbg_win;
   logic xfer;
   tag_t tag_in;
   tag_t tag_out;

   // last_grant: 0 = core, 1 = dbg; the requester not granted last wins a tie
   assign core_win = reset_n && core.valid && (!dbg.valid || last_grant);
   assign dbg_win  = reset_n && dbg.valid && !core_win;
   assign xfer     = core_win || dbg_win;
   assign core.ready = core_win;
   assign dbg.ready  = dbg_win;

   always_comb begin
      mem_addr     = core_win ? core.addr : dbg_win ? dbg.addr : '0;
      mem_w_data   = core_win ? core.w_data : dbg_win ? dbg.w_data : '0;
      mem_w_width  = core_win ? core.w_width : dbg_win ? dbg.w_width : write_width_t'('0);
      mem_w_enable = core_win ? core.w_enable : dbg_win && dbg.w_enable;
   end

   assign tag_in = {xfer, dbg_win, mem_w_enable};

   if (READ_LATENCY == 0) begin : g_lat0
      assign tag_out = tag_in;
   end else if (READ_LATENCY == 1) begin : g_lat1
      tag_t tag_q;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) tag_q <= '0;
         else tag_q <= tag_in;
      end
      assign tag_out = tag_q;
   end else begin : g_bad
      $error("data_mem_arbiter: READ_LATENCY must be 0 or 1");
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) last_grant <= 1'b1;
      else if (xfer) last_grant <= dbg_win;
   end

   // the tag leaving the pipeline lines up with the cycle mem_r_data is valid
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         core.rsp_valid  <= 1'b0;
         dbg.rsp_valid   <= 1'b0;
         core.rsp_r_data <= '0;
         dbg.rsp_r_data  <= '0;
      end else begin
         core.rsp_valid <= tag_out.vld && !tag_out.own;
         dbg.rsp_valid  <= tag_out.vld && tag_out.own;
         if (tag_out.vld && !tag_out.own) core.rsp_r_data <= tag_out.wr ? '0 : mem_r_data;
         if (tag_out.vld && tag_out.own) dbg.rsp_r_data <= tag_out.wr ? '0 : mem_r_data;
      end
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: drives identical stimulus into READ_LATENCY 0 and 1 instances,
// checking grants, memory drive and scoreboarded responses every cycle.
module tb_data_mem_arbiter;
   import data_mem_pkg::*;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   data_mem_arbiter_if ci0 ();
   data_mem_arbiter_if di0 ();
   data_mem_arbiter_if ci1 ();
   data_mem_arbiter_if di1 ();

   logic [31:0]  ma0, mwd0, mrd0, ma1, mwd1, mrd1;
   write_width_t mww0, mww1;
   logic         mwe0, mwe1;

   data_mem_arbiter #(.READ_LATENCY(0)) u0 (
      .clock(clock), .reset_n(reset_n), .core(ci0), .dbg(di0),
      .mem_addr(ma0), .mem_w_data(mwd0), .mem_w_width(mww0),
      .mem_w_enable(mwe0), .mem_r_data(mrd0)
   );

   data_mem_arbiter #(.READ_LATENCY(1)) u1 (
      .clock(clock), .reset_n(reset_n), .core(ci1), .dbg(di1),
      .mem_addr(ma1), .mem_w_data(mwd1), .mem_w_width(mww1),
      .mem_w_enable(mwe1), .mem_r_data(mrd1)
   );

   logic [31:0] mem0 [64];
   logic [31:0] mem1 [64];
   logic [31:0] ref_mem [64];

   function automatic logic [31:0] init_word(int i);
      return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | i);
   endfunction

   // memory models: combinational read for latency 0, registered read for latency 1
   always @(posedge clock) begin
      if (!reset_n) for (int i = 0; i < 64; i++) mem0[i] <= init_word(i);
      else if (mwe0) mem0[ma0[7:2]] <= mwd0;
   end
   assign mrd0 = mem0[ma0[7:2]];

   always @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) mem1[i] <= init_word(i);
         mrd1 <= '0;
      end else begin
         if (mwe1) mem1[ma1[7:2]] <= mwd1;
         mrd1 <= mem1[ma1[7:2]];
      end
   end

   int          nchk = 0;
   int          nerr = 0;
   int          cyc = 0;
   logic        lg;
   exp_t        q [4][$];
   logic [31:0] last [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic cv, input logic [31:0] ca, input logic [31:0] cd, input logic cwe,
                        input logic dv, input logic [31:0] da, input logic [31:0] dd, input logic dwe);
      ci0.valid = cv; ci0.addr = ca; ci0.w_data = cd; ci0.w_enable = cwe; ci0.w_width = WORD;
      ci1.valid = cv; ci1.addr = ca; ci1.w_data = cd; ci1.w_enable = cwe; ci1.w_width = WORD;
      di0.valid = dv; di0.addr = da; di0.w_data = dd; di0.w_enable = dwe; di0.w_width = WORD;
      di1.valid = dv; di1.addr = da; di1.w_data = dd; di1.w_enable = dwe; di1.w_width = WORD;
   endtask

   task automatic rsp_chk(input int k, input logic v, input logic [31:0] d, input string tag);
      exp_t e;
      if (v) begin
         if (q[k].size() == 0) check({tag, "_spurious"}, v, 0);
         else begin
            e = q[k].pop_front();
            check({tag, "_cycle"}, cyc, e.cyc);
            check({tag, "_data"}, d, e.data);
         end
         last[k] = d;
      end else begin
         check({tag, "_hold"}, d, last[k]);
         if (q[k].size() != 0 && q[k][0].cyc <= cyc) begin
            check({tag, "_missing"}, v, 1);
            void'(q[k].pop_front());
         end
      end
   endtask

   task automatic step(input logic cv, input logic [31:0] ca, input logic [31:0] cd, input logic cwe,
                       input logic dv, input logic [31:0] da, input logic [31:0] dd, input logic dwe);
      logic        gc, gd, we;
      logic [31:0] a, d;
      int          k;
      drive(cv, ca, cd, cwe, dv, da, dd, dwe);
      #1;
      gc = cv && (!dv || lg);
      gd = dv && !gc;
      we = gc ? cwe : (gd && dwe);
      a  = gc ? ca : gd ? da : 32'h0;
      check("core_ready0", ci0.ready, gc);
      check("dbg_ready0", di0.ready, gd);
      check("core_ready1", ci1.ready, gc);
      check("dbg_ready1", di1.ready, gd);
      check("mem_addr0", ma0, a);
      check("mem_addr1", ma1, a);
      check("mem_we0", mwe0, we);
      check("mem_we1", mwe1, we);
      check("mem_wdata0", mwd0, gc ? cd : gd ? dd : 32'h0);
      check("mem_width0", mww0, (gc || gd) ? WORD : BYTE);
      if (gc || gd) begin
         k = gd ? 1 : 0;
         d = we ? 32'h0 : ref_mem[a[7:2]];
         q[k].push_back('{cyc + 1, d});
         q[k + 2].push_back('{cyc + 2, d});
         if (we) ref_mem[a[7:2]] = gc ? cd : dd;
         lg = gd;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
      rsp_chk(0, ci0.rsp_valid, ci0.rsp_r_data, "core_rsp_lat0");
      rsp_chk(1, di0.rsp_valid, di0.rsp_r_data, "dbg_rsp_lat0");
      rsp_chk(2, ci1.rsp_valid, ci1.rsp_r_data, "core_rsp_lat1");
      rsp_chk(3, di1.rsp_valid, di1.rsp_r_data, "dbg_rsp_lat1");
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(1, 32'h00020010, 0, 0, 1, 32'h00020004, 0, 0);
      #1;
      check("rst_core_ready0", ci0.ready, 0);
      check("rst_dbg_ready1", di1.ready, 0);
      check("rst_mem_addr0", ma0, 0);
      check("rst_mem_we1", mwe1, 0);
      for (int k = 0; k < 4; k++) begin
         q[k].delete();
         last[k] = '0;
      end
      @(posedge clock);
      @(posedge clock);
      #1;
      check("rst_core_rv0", ci0.rsp_valid, 0);
      check("rst_dbg_rv0", di0.rsp_valid, 0);
      check("rst_core_rv1", ci1.rsp_valid, 0);
      check("rst_dbg_rv1", di1.rsp_valid, 0);
      check("rst_core_rd0", ci0.rsp_r_data, 0);
      check("rst_dbg_rd0", di0.rsp_r_data, 0);
      check("rst_core_rd1", ci1.rsp_r_data, 0);
      check("rst_dbg_rd1", di1.rsp_r_data, 0);
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      lg = 1'b1;
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      repeat (4) step(1, 32'h00020000, 0, 0, 1, 32'h00020004, 0, 0);
      step(1, 32'h00020010, 0, 0, 0, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 1, 32'h00020008, 32'h12345678, 1);
      step(1, 32'h00020008, 0, 0, 0, 0, 0, 0);
      step(1, 32'h0002000C, 0, 0, 0, 0, 0, 0);
      step(1, 32'h00020010, 0, 0, 0, 0, 0, 0);
      step(1, 32'h00020014, 0, 0, 0, 0, 0, 0);
      idle(5);
      step(0, 0, 0, 0, 1, 32'h00020024, 0, 0);
      step(1, 32'h00020018, 0, 0, 1, 32'h00020020, 32'hCAFEF00D, 1);
      step(0, 0, 0, 0, 1, 32'h00020020, 32'hCAFEF00D, 1);
      step(1, 32'h00020020, 0, 0, 0, 0, 0, 0);
      idle(3);
      step(1, 32'h00020010, 0, 0, 0, 0, 0, 0);
      do_reset();
      idle(3);
      step(1, 32'h00020000, 0, 0, 1, 32'h00020004, 0, 0);
      idle(3);
      for (int k = 0; k < 4; k++) check("drain", q[k].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end
endmodule
